// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, opcodes, FSM states
// and instruction field positions.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int ADDR_W = 3;
    localparam int IMM_W  = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic KIND_ALU = 1'b0;
    localparam logic KIND_LDI = 1'b1;

    // Instruction layout: [15] kind, [14:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm
    localparam int KIND_BIT = 15;
    localparam int OP_HI    = 14;
    localparam int OP_LO    = 13;
    localparam int RD_HI    = 12;
    localparam int RD_LO    = 10;
    localparam int RS1_HI   = 9;
    localparam int RS1_LO   = 7;
    localparam int RS2_HI   = 6;
    localparam int RS2_LO   = 4;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundles the instruction handshake, the ALU operand/result bus and the
// write-back report of the issue controller.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_o;
    logic              alu_cout;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  instr_valid, instr, alu_o, alu_cout,
        output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
    );

    modport slave (
        output instr_valid, instr, alu_o, alu_cout,
        input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero, whole array cleared by asynchronous reset.
module alu_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int RAW  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [RAW-1:0] raddr_a,
    input  logic [RAW-1:0] raddr_b,
    output logic [DW-1:0]  rdata_a,
    output logic [DW-1:0]  rdata_b,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 2-bit-opcode ALU: accepts, decodes, reads
// operands, drives the ALU and writes back. ALU_FLAGS_EN adds z/n/c flag outputs.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW   = DATA_W,
    parameter int NREG = REG_N,
    parameter int RAW  = ADDR_W
) (
    input  logic clk,
    input  logic reset,
    alu_issue_ctrl_if.master bus,
`ifdef ALU_FLAGS_EN
    output logic flag_z,
    output logic flag_n,
    output logic flag_c,
`endif
    output logic busy
);

    state_t         state;
    logic [1:0]     op_q;
    logic [RAW-1:0] rd_q;
    logic [RAW-1:0] rs1_q;
    logic [RAW-1:0] rs2_q;
    logic [DW-1:0]  result_q;
    logic [DW-1:0]  rdata_a;
    logic [DW-1:0]  rdata_b;

`ifdef ALU_FLAGS_EN
    logic kind_q;
    logic cout_q;
`else
    logic unused_cout;
    assign unused_cout = bus.alu_cout;
`endif

    alu_regfile #(
        .DW  (DW),
        .NREG(NREG),
        .RAW (RAW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr_a(rs1_q),
        .raddr_b(rs2_q),
        .rdata_a(rdata_a),
        .rdata_b(rdata_b),
        .we     (state == WB),
        .waddr  (rd_q),
        .wdata  (result_q)
    );

    // The register write lands on the edge leaving WB, so a following READ sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            op_q            <= OP_ADD;
            rd_q            <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            result_q        <= '0;
            bus.instr_ready <= 1'b1;
            bus.alu_op      <= OP_ADD;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_addr     <= '0;
            bus.wb_data     <= '0;
            busy            <= 1'b0;
`ifdef ALU_FLAGS_EN
            kind_q          <= KIND_ALU;
            cout_q          <= 1'b0;
            flag_z          <= 1'b0;
            flag_n          <= 1'b0;
            flag_c          <= 1'b0;
`endif
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        op_q            <= bus.instr[OP_HI:OP_LO];
                        rd_q            <= bus.instr[RD_HI:RD_LO];
                        rs1_q           <= bus.instr[RS1_HI:RS1_LO];
                        rs2_q           <= bus.instr[RS2_HI:RS2_LO];
                        bus.instr_ready <= 1'b0;
                        busy            <= 1'b1;
`ifdef ALU_FLAGS_EN
                        kind_q          <= bus.instr[KIND_BIT];
`endif
                        if (bus.instr[KIND_BIT] == KIND_LDI) begin
                            result_q <= {{(DW-IMM_W){1'b0}}, bus.instr[IMM_HI:IMM_LO]};
                            state    <= WB;
                        end else begin
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    bus.alu_op <= op_q;
                    bus.alu_a  <= rdata_a;
                    bus.alu_b  <= rdata_b;
                    state      <= EXEC;
                end
                EXEC: begin
                    result_q <= bus.alu_o;
`ifdef ALU_FLAGS_EN
                    cout_q   <= bus.alu_cout;
`endif
                    state    <= WB;
                end
                WB: begin
                    bus.wb_valid    <= 1'b1;
                    bus.wb_addr     <= rd_q;
                    bus.wb_data     <= result_q;
                    bus.instr_ready <= 1'b1;
                    busy            <= 1'b0;
`ifdef ALU_FLAGS_EN
                    if (kind_q == KIND_ALU) begin
                        flag_z <= (result_q == '0);
                        flag_n <= result_q[DW-1];
                        flag_c <= cout_q;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model;
// flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk;
    logic reset;
    logic busy;
    int   tests;
    int   fails;
`ifdef ALU_FLAGS_EN
    logic flag_z;
    logic flag_n;
    logic flag_c;
`endif

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
`ifdef ALU_FLAGS_EN
        .flag_z(flag_z),
        .flag_n(flag_n),
        .flag_c(flag_c),
`endif
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU seen by the controller; sub carry is a + ~b + 1.
    always_comb begin
        logic [16:0] s;
        s = '0;
        case (bus.alu_op)
            OP_ADD:  s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OP_SUB:  s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
            OP_AND:  s = {1'b0, bus.alu_a & bus.alu_b};
            default: s = {1'b0, bus.alu_a | bus.alu_b};
        endcase
        bus.alu_o    = s[15:0];
        bus.alu_cout = s[16];
    end

    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs1, input logic [2:0] rs2);
        return {KIND_ALU, op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {KIND_LDI, 2'b00, rd, 2'b00, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds the word valid until accepted; returns one step after the accepting edge.
    task automatic issue(input string tag, input logic [15:0] w);
        int k;
        k = 0;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        while (bus.instr_ready !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_wb(input string tag, input int exp_lat,
                           input logic [2:0] exp_addr, input logic [15:0] exp_data);
        int k;
        k = 0;
        while (bus.wb_valid !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "_latency"},  32'(k),            32'(exp_lat));
        check({tag, "_wb_addr"},  32'(bus.wb_addr),  32'(exp_addr));
        check({tag, "_wb_data"},  32'(bus.wb_data),  32'(exp_data));
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        tick();
        tick();

        check("rst_ready",    32'(bus.instr_ready), 32'd1);
        check("rst_busy",     32'(busy),            32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid),    32'd0);
        check("rst_alu_op",   32'(bus.alu_op),      32'd0);
        check("rst_alu_a",    32'(bus.alu_a),       32'd0);
        check("rst_alu_b",    32'(bus.alu_b),       32'd0);
        check("rst_wb_data",  32'(bus.wb_data),     32'd0);
`ifdef ALU_FLAGS_EN
        check("rst_flags", 32'({flag_z, flag_n, flag_c}), 32'd0);
`endif
        reset = 1'b0;
        tick();

        issue("ldi_r1", enc_ldi(3'd1, 8'h34));
        check("ldi_busy", 32'(busy), 32'd1);
        wait_wb("ldi_r1", 1, 3'd1, 16'h0034);
        issue("ldi_r2", enc_ldi(3'd2, 8'h12));
        wait_wb("ldi_r2", 1, 3'd2, 16'h0012);

        issue("add", enc_alu(OP_ADD, 3'd3, 3'd1, 3'd2));
        check("add_read_ready", 32'(bus.instr_ready), 32'd0);
        wait_wb("add", 3, 3'd3, 16'h0046);
        check("add_alu_op", 32'(bus.alu_op), 32'd0);
        check("add_alu_a",  32'(bus.alu_a),  32'h0034);
        check("add_alu_b",  32'(bus.alu_b),  32'h0012);

        issue("ldi_r1z", enc_ldi(3'd1, 8'h00));
        check("hold_alu_a", 32'(bus.alu_a), 32'h0034);
        wait_wb("ldi_r1z", 1, 3'd1, 16'h0000);
        issue("ldi_r2o", enc_ldi(3'd2, 8'h01));
        wait_wb("ldi_r2o", 1, 3'd2, 16'h0001);

        issue("sub", enc_alu(OP_SUB, 3'd4, 3'd1, 3'd2));
        wait_wb("sub", 3, 3'd4, 16'hFFFF);
        check("sub_alu_op", 32'(bus.alu_op), 32'd1);
`ifdef ALU_FLAGS_EN
        check("sub_flag_n", 32'(flag_n), 32'd1);
        check("sub_flag_z", 32'(flag_z), 32'd0);
        check("sub_flag_c", 32'(flag_c), 32'd0);
`endif

        // Valid held high across two instructions: the second waits for IDLE.
        bus.instr       = enc_alu(OP_AND, 3'd6, 3'd4, 3'd2);
        bus.instr_valid = 1'b1;
        check("b2b_first_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr = enc_alu(OP_ADD, 3'd7, 3'd6, 3'd4);
        check("b2b_read_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        check("b2b_exec_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        check("b2b_wb_ready",   32'(bus.instr_ready), 32'd0);
        tick();
        check("b2b_a_wb_valid", 32'(bus.wb_valid),    32'd1);
        check("b2b_a_wb_addr",  32'(bus.wb_addr),     32'd6);
        check("b2b_a_wb_data",  32'(bus.wb_data),     32'h0001);
        check("b2b_idle_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        check("b2b_b_busy", 32'(busy), 32'd1);
        wait_wb("b2b_b", 3, 3'd7, 16'h0000);
        tick();
        check("b2b_no_dup_wb", 32'(bus.wb_valid), 32'd0);
`ifdef ALU_FLAGS_EN
        check("b2b_flag_z", 32'(flag_z), 32'd1);
        check("b2b_flag_c", 32'(flag_c), 32'd1);
`endif

        issue("ldi_r0", enc_ldi(3'd0, 8'hFF));
        wait_wb("ldi_r0", 1, 3'd0, 16'h00FF);
`ifdef ALU_FLAGS_EN
        check("ldi_keeps_flag_z", 32'(flag_z), 32'd1);
`endif
        issue("or_r0", enc_alu(OP_OR, 3'd5, 3'd0, 3'd0));
        wait_wb("or_r0", 3, 3'd5, 16'h0000);

        // Reset in EXEC drops the instruction and clears the register file.
        issue("and_rst", enc_alu(OP_AND, 3'd6, 3'd3, 3'd3));
        tick();
        check("exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy",  32'(busy),            32'd0);
        check("midrst_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_wb", 32'(bus.wb_valid), 32'd0);
            tick();
        end
        check("midrst_idle_busy", 32'(busy), 32'd0);
        issue("post_rst", enc_alu(OP_ADD, 3'd1, 3'd3, 3'd4));
        wait_wb("post_rst", 3, 3'd1, 16'h0000);
        check("post_rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("post_rst_alu_b", 32'(bus.alu_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
